apb4_master_arbiter: RTL and testbench
======================================

// Module: apb4_master_arbiter
// PURPOSE
//  Arbitrates NUM_REQ on-chip requesters onto one shared APB4 master port. Selection is round-robin.
//  Runs the APB4 SETUP/ACCESS phases and returns read data and error status to the winning requester.
//  Synthesizable counterpart of the testbench APB4 master model. Sits between DMA/CPU-side register
//  clients and the APB4 peripheral bus.
// PARAMETERS
//  NUM_REQ     4      number of requesters (2..16)
//  ADDR_WIDTH  32     paddr / req_addr width
//  DATA_WIDTH  32     pwdata / prdata width (pstrb width = DATA_WIDTH/8)
//  PPROT       3'b000 constant driven on pprot_o
// PORTS
//  clk_i         in   1                    clock; also APB4 pclk
//  rst_i         in   1                    synchronous reset, active-high
//  req_valid_i   in   NUM_REQ              per-requester transfer request
//  req_write_i   in   NUM_REQ              1=write 0=read
//  req_addr_i    in   NUM_REQ*ADDR_WIDTH   packed addresses; requester k at [k*ADDR_WIDTH +: ADDR_WIDTH]
//  req_wdata_i   in   NUM_REQ*DATA_WIDTH   packed write data
//  req_ready_o   out  NUM_REQ              one-hot accept pulse
//  rsp_valid_o   out  NUM_REQ              one-hot completion pulse
//  rsp_rdata_o   out  DATA_WIDTH           read data; meaningful only with rsp_valid_o
//  rsp_err_o     out  1                    registered pslverr; meaningful only with rsp_valid_o
//  busy_o        out  1                    1 whenever the FSM is not IDLE
//  paddr_o       out  ADDR_WIDTH           APB4 address
//  pprot_o       out  3                    APB4 protection = PPROT
//  psel_o        out  1                    APB4 select
//  penable_o     out  1                    APB4 enable
//  pwrite_o      out  1                    APB4 direction
//  pwdata_o      out  DATA_WIDTH           APB4 write data
//  pstrb_o       out  DATA_WIDTH/8         all ones on writes, all zeros on reads
//  pready_i      in   1                    APB4 ready
//  prdata_i      in   DATA_WIDTH           APB4 read data
//  pslverr_i     in   1                    APB4 slave error
// BEHAVIOUR
//  Reset values: FSM=IDLE, rr pointer=0, all outputs 0 (paddr/pwdata/pstrb/rsp_rdata = 0).
//  All APB outputs are driven from registers.
//  FSM states:
//   IDLE:   if any req_valid_i, grant the first set bit searching from ptr, ptr+1, ... (mod NUM_REQ).
//           Same cycle: req_ready_o[g]=1 (combinational from req_valid_i and state).
//           Latch addr/wdata/write of g. Next state SETUP; ptr <= (g+1) mod NUM_REQ.
//   SETUP:  psel=1, penable=0, paddr/pwrite/pwdata/pstrb valid. Next state is always ACCESS.
//   ACCESS: psel=1, penable=1; hold all APB outputs stable while pready_i=0 (unbounded wait).
//           On pready_i=1: capture prdata_i (reads only; unchanged on writes) and pslverr_i.
//           Next state is RESP.
//   RESP:   psel=0, penable=0; rsp_valid_o[g]=1 for exactly one cycle with rsp_rdata_o/rsp_err_o.
//           Next state is IDLE.
//  Latency: accept at T -> SETUP at T+1 -> ACCESS at T+2 -> (zero wait) rsp_valid at T+3.
//           Next accept no earlier than T+4. Each pready_i=0 cycle adds one cycle.
//  Requester rules: hold req_valid/addr/wdata/write stable until req_ready.
//   Deasserting req_valid before grant is allowed (no transfer occurs).
//   req_valid in the accept cycle is a new request only if held after req_ready.
//  Arbitration boundaries:
//   - Requests arriving while busy_o=1 wait; no preemption.
//   - A single requester may win back-to-back when it is the only one requesting.
//   - ptr wraps from NUM_REQ-1 to 0.
//  pslverr is passed through as rsp_err_o; no retry. rsp_rdata_o holds its last value between responses.
//  Reset in any state (incl. mid-ACCESS): next cycle psel/penable=0, FSM=IDLE, no rsp_valid.
//   The interrupted requester gets no response.
//  pready_i/pslverr_i/prdata_i are ignored outside ACCESS.
// TESTING
//  1 Req0 write addr 0x10 data 0xDEADBEEF, pready=1 -> SETUP then ACCESS 1 cycle each; pstrb=4'hF;
//    rsp_valid[0] 3 cycles after accept; rsp_err=0.
//  2 Req2 read addr 0x24, pready low 2 ACCESS cycles, prdata=0x12345678 -> APB signals stable 3 cycles;
//    rsp_rdata=0x12345678, pstrb=0.
//  3 All 4 req_valid held from reset release -> grant order 0,1,2,3,0; no requester granted twice
//    while another waits.
//  4 Req1 write with pslverr=1 -> rsp_valid[1] with rsp_err=1; next transfer err=0.
//  5 rst_i asserted during ACCESS with pready=0 -> psel=penable=0 next cycle; no rsp_valid; ptr=0;
//    new request after release is granted to lowest index.
//  6 Only req3 requesting, repeated -> back-to-back grants to 3 every 4 cycles; busy_o low only 1 cycle each.

Source files
------------

// File: rtl/apb4_master_arbiter.sv
// Round-robin arbiter that funnels NUM_REQ register clients onto one APB4 master port.
// Each accepted request runs SETUP -> ACCESS (wait on pready) -> RESP before the next grant.
module apb4_master_arbiter #(
  parameter int          NUM_REQ    = 4,
  parameter int          ADDR_WIDTH = 32,
  parameter int          DATA_WIDTH = 32,
  parameter logic [2:0]  PPROT      = 3'b000
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NUM_REQ-1:0]              req_valid_i,
  input  logic [NUM_REQ-1:0]              req_write_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata_i,
  output logic [NUM_REQ-1:0]              req_ready_o,
  output logic [NUM_REQ-1:0]              rsp_valid_o,
  output logic [DATA_WIDTH-1:0]           rsp_rdata_o,
  output logic                            rsp_err_o,
  output logic                            busy_o,
  output logic [ADDR_WIDTH-1:0]           paddr_o,
  output logic [2:0]                      pprot_o,
  output logic                            psel_o,
  output logic                            penable_o,
  output logic                            pwrite_o,
  output logic [DATA_WIDTH-1:0]           pwdata_o,
  output logic [DATA_WIDTH/8-1:0]         pstrb_o,
  input  logic                            pready_i,
  input  logic [DATA_WIDTH-1:0]           prdata_i,
  input  logic                            pslverr_i
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SW = DATA_WIDTH / 8;
  localparam logic [PW:0]   NUM_REQ_W = (PW+1)'(NUM_REQ);
  localparam logic [PW-1:0] LAST_IDX  = PW'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [PW-1:0]          ptr_q, ptr_d;
  logic [PW-1:0]          gnt_q, gnt_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
  logic [SW-1:0]          strb_q, strb_d;
  logic                   write_q, write_d;
  logic                   psel_q, psel_d;
  logic                   penable_q, penable_d;
  logic                   err_q, err_d;
  logic [NUM_REQ-1:0]     rsp_valid_q, rsp_valid_d;

  logic                   found;
  logic [PW-1:0]          pick;
  logic [PW:0]            cand;

  // First requesting index at or after ptr_q, wrapping at NUM_REQ.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, ptr_q} + (PW+1)'(i);
      if (cand >= NUM_REQ_W) cand = cand - NUM_REQ_W;
      if (!found && req_valid_i[cand[PW-1:0]]) begin
        found = 1'b1;
        pick  = cand[PW-1:0];
      end
    end
  end

  // Handshake: a requester holds req_valid and its payload until it sees its req_ready
  // bit, which is a single-cycle accept pulse raised only while idle; the matching
  // rsp_valid bit pulses once when the APB transfer has completed.
  always_comb begin
    req_ready_o = '0;
    if (state_q == S_IDLE && found) req_ready_o[pick] = 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    strb_d      = strb_q;
    write_d     = write_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    err_d       = err_q;
    rsp_valid_d = '0;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d   = S_SETUP;
          gnt_d     = pick;
          ptr_d     = (pick == LAST_IDX) ? '0 : pick + 1'b1;
          addr_d    = req_addr_i[pick*ADDR_WIDTH +: ADDR_WIDTH];
          wdata_d   = req_wdata_i[pick*DATA_WIDTH +: DATA_WIDTH];
          write_d   = req_write_i[pick];
          strb_d    = req_write_i[pick] ? '1 : '0;
          psel_d    = 1'b1;
          penable_d = 1'b0;
        end
      end
      S_SETUP: begin
        state_d   = S_ACCESS;
        penable_d = 1'b1;
      end
      S_ACCESS: begin
        if (pready_i) begin
          state_d            = S_RESP;
          psel_d             = 1'b0;
          penable_d          = 1'b0;
          err_d              = pslverr_i;
          rsp_valid_d[gnt_q] = 1'b1;
          if (!write_q) rdata_d = prdata_i;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      gnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      strb_q      <= '0;
      write_q     <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      err_q       <= 1'b0;
      rsp_valid_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      strb_q      <= strb_d;
      write_q     <= write_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      err_q       <= err_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;
  assign busy_o      = (state_q != S_IDLE);
  assign paddr_o     = addr_q;
  assign pprot_o     = PPROT;
  assign psel_o      = psel_q;
  assign penable_o   = penable_q;
  assign pwrite_o    = write_q;
  assign pwdata_o    = wdata_q;
  assign pstrb_o     = strb_q;

endmodule

// File: tb/tb_apb4_master_arbiter.sv
// Directed bench for apb4_master_arbiter: table of single transfers plus
// round-robin, back-to-back and reset-during-ACCESS sequences.
module tb_apb4_master_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_write;
  logic [N*AW-1:0]   req_addr;
  logic [N*DW-1:0]   req_wdata;
  logic [N-1:0]      req_ready;
  logic [N-1:0]      rsp_valid;
  logic [DW-1:0]     rsp_rdata;
  logic              rsp_err;
  logic              busy;
  logic [AW-1:0]     paddr;
  logic [2:0]        pprot;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [DW-1:0]     pwdata;
  logic [DW/8-1:0]   pstrb;
  logic              pready;
  logic [DW-1:0]     prdata;
  logic              pslverr;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [1:0]  idx;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;
    logic [31:0] prdata;
    logic        err;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t         vecs [6];
  logic [N-1:0] exp_q [$];

  always #5 clk = ~clk;

  apb4_master_arbiter #(
    .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PPROT(3'b000)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_write_i(req_write),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .req_ready_o(req_ready), .rsp_valid_o(rsp_valid),
    .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err), .busy_o(busy),
    .paddr_o(paddr), .pprot_o(pprot), .psel_o(psel), .penable_o(penable),
    .pwrite_o(pwrite), .pwdata_o(pwdata), .pstrb_o(pstrb),
    .pready_i(pready), .prdata_i(prdata), .pslverr_i(pslverr)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    pready    = 1'b0;
    pslverr   = 1'b0;
    prdata    = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Caller has just driven requests after a posedge; returns at the grant cycle's negedge.
  task automatic wait_grant(input logic [N-1:0] exp, input string nm, output int n);
    n = 0;
    @(negedge clk);
    while (req_ready == '0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(nm, req_ready, exp);
  endtask

  task automatic xfer(input vec_t v, input string nm);
    int n;
    logic [N-1:0] oh;
    logic [DW/8-1:0] strb;
    oh   = N'(1) << v.idx;
    strb = v.wr ? '1 : '0;
    @(posedge clk); #1;
    req_valid[v.idx]          = 1'b1;
    req_write[v.idx]          = v.wr;
    req_addr[v.idx*AW +: AW]  = v.addr;
    req_wdata[v.idx*DW +: DW] = v.wdata;
    wait_grant(oh, {nm, ".grant"}, n);
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    check({nm, ".setup.psel"}, psel, 1'b1);
    check({nm, ".setup.penable"}, penable, 1'b0);
    check({nm, ".setup.paddr"}, paddr, v.addr);
    check({nm, ".setup.pwrite"}, pwrite, v.wr);
    check({nm, ".setup.pstrb"}, pstrb, strb);
    check({nm, ".setup.busy"}, busy, 1'b1);
    if (v.wr) check({nm, ".setup.pwdata"}, pwdata, v.wdata);
    for (int w = 0; w <= v.waits; w++) begin
      @(posedge clk); #1;
      pready  = (w == v.waits);
      prdata  = (w == v.waits) ? v.prdata : (32'hFFFF_0000 | w);
      pslverr = (w == v.waits) ? v.err : 1'b1;
      @(negedge clk);
      check({nm, ".access.psel"}, psel, 1'b1);
      check({nm, ".access.penable"}, penable, 1'b1);
      check({nm, ".access.paddr"}, paddr, v.addr);
      check({nm, ".access.pwrite"}, pwrite, v.wr);
      check({nm, ".access.pstrb"}, pstrb, strb);
      check({nm, ".access.rsp_valid"}, rsp_valid, '0);
    end
    @(posedge clk); #1;
    pready  = 1'b0;
    pslverr = 1'b0;
    prdata  = 32'hDEAD_0000;
    @(negedge clk);
    check({nm, ".resp.rsp_valid"}, rsp_valid, oh);
    check({nm, ".resp.rdata"}, rsp_rdata, v.exp_rdata);
    check({nm, ".resp.err"}, rsp_err, v.exp_err);
    check({nm, ".resp.psel"}, psel, 1'b0);
    check({nm, ".resp.penable"}, penable, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    check({nm, ".idle.busy"}, busy, 1'b0);
    check({nm, ".idle.rsp_valid"}, rsp_valid, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    //        idx   wr    addr          wdata         waits prdata        err   exp_rdata     exp_err
    vecs[0] = '{2'd0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 32'h5555_5555, 1'b0, 32'h0000_0000, 1'b0};
    vecs[1] = '{2'd2, 1'b0, 32'h0000_0024, 32'h0000_0000, 2, 32'h1234_5678, 1'b0, 32'h1234_5678, 1'b0};
    vecs[2] = '{2'd1, 1'b1, 32'h0000_0030, 32'hCAFE_F00D, 0, 32'h6666_6666, 1'b1, 32'h1234_5678, 1'b1};
    vecs[3] = '{2'd1, 1'b0, 32'h0000_0034, 32'h0000_0000, 1, 32'hA5A5_0001, 1'b0, 32'hA5A5_0001, 1'b0};
    vecs[4] = '{2'd3, 1'b0, 32'h0000_003C, 32'h0000_0000, 0, 32'h0BAD_F00D, 1'b1, 32'h0BAD_F00D, 1'b1};
    vecs[5] = '{2'd0, 1'b1, 32'h0000_0040, 32'h0000_0001, 3, 32'h7777_7777, 1'b0, 32'h0BAD_F00D, 1'b0};

    // Reset values
    do_reset();
    @(negedge clk);
    check("reset.req_ready", req_ready, '0);
    check("reset.rsp_valid", rsp_valid, '0);
    check("reset.psel", psel, 1'b0);
    check("reset.penable", penable, 1'b0);
    check("reset.busy", busy, 1'b0);
    check("reset.paddr", paddr, '0);
    check("reset.pwdata", pwdata, '0);
    check("reset.pstrb", pstrb, '0);
    check("reset.pwrite", pwrite, 1'b0);
    check("reset.rdata", rsp_rdata, '0);
    check("reset.err", rsp_err, 1'b0);
    check("reset.pprot", pprot, 3'b000);

    for (int i = 0; i < 6; i++) xfer(vecs[i], $sformatf("vec%0d", i));

    // All four requesting from reset release: strict rotation with wrap 3 -> 0.
    do_reset();
    pready = 1'b1;
    exp_q  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    @(posedge clk); #1;
    req_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      wait_grant(exp_q.pop_front(), $sformatf("rr.grant%0d", k), n);
      if (k > 0) check($sformatf("rr.spacing%0d", k), n, 3);
    end
    @(posedge clk); #1;
    req_valid = '0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rr.drain.busy", busy, 1'b0);

    // Lone requester 3: grant every 4 cycles, busy low only in the grant cycle.
    do_reset();
    pready = 1'b1;
    @(posedge clk); #1;
    req_valid = 4'b1000;
    wait_grant(4'b1000, "b2b.grant0", n);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      check($sformatf("b2b.ready%0d", i), req_ready, (i % 4 == 0) ? 4'b1000 : 4'b0000);
      check($sformatf("b2b.busy%0d", i), busy, (i % 4 != 0));
      check($sformatf("b2b.rsp%0d", i), rsp_valid, (i % 4 == 3) ? 4'b1000 : 4'b0000);
    end
    @(posedge clk); #1;
    req_valid = '0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("b2b.drain.busy", busy, 1'b0);

    // Reset while stalled in ACCESS: bus drops, no response, pointer back to 0.
    do_reset();
    @(posedge clk); #1;
    req_valid[2]         = 1'b1;
    req_addr[2*AW +: AW] = 32'h0000_0050;
    wait_grant(4'b0100, "rst.grant", n);
    @(posedge clk); #1;
    req_valid = '0;
    pready    = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst.access.penable", penable, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst.after.psel", psel, 1'b0);
    check("rst.after.penable", penable, 1'b0);
    check("rst.after.busy", busy, 1'b0);
    check("rst.after.rsp_valid", rsp_valid, '0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      pready = 1'b1;
      @(negedge clk);
      check($sformatf("rst.no_rsp%0d", i), rsp_valid, '0);
    end
    @(posedge clk); #1;
    req_valid             = 4'b1010;
    req_write             = 4'b1010;
    req_addr[1*AW +: AW]  = 32'h0000_0060;
    req_wdata[1*DW +: DW] = 32'h1111_2222;
    wait_grant(4'b0010, "rst.regrant", n);
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    check("rst.regrant.paddr", paddr, 32'h0000_0060);
    check("rst.regrant.pwdata", pwdata, 32'h1111_2222);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst.regrant.rsp_valid", rsp_valid, 4'b0010);
    check("rst.regrant.err", rsp_err, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    check("rst.regrant.busy", busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
